// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: one full-adder cell plus a carry flop, LSB first.
// Optional add mode (a + b) is enabled by defining SERIAL_SUBTRACTOR_ADD_MODE_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    input  logic             op_add,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  aSh_q, aSh_d;
    logic [WIDTH-1:0]  bnSh_q, bnSh_d;
    logic              carry_q, carry_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              aMsb_q, aMsb_d;
    logic              bMsb_q, bMsb_d;
    logic              addMode_q, addMode_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              borrow_q, borrow_d;
    logic              overflow_q, overflow_d;

    logic              addSel;
    logic              sumBit;
    logic              carryOut;
    logic              lastBit;

`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    assign addSel = op_add;
`else
    assign addSel = 1'b0;
`endif

    assign sumBit   = aSh_q[0] ^ bnSh_q[0] ^ carry_q;
    assign carryOut = (aSh_q[0] & bnSh_q[0]) | (aSh_q[0] & carry_q) | (bnSh_q[0] & carry_q);
    assign lastBit  = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (lastBit)   state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1; add mode keeps b as-is and starts with carry 0.
    always_comb begin
        aSh_d      = aSh_q;
        bnSh_d     = bnSh_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        aMsb_d     = aMsb_q;
        bMsb_d     = bMsb_q;
        addMode_d  = addMode_q;
        diff_d     = diff_q;
        borrow_d   = borrow_q;
        overflow_d = overflow_q;
        if (state_q == IDLE && in_valid) begin
            aSh_d     = a;
            bnSh_d    = addSel ? b : ~b;
            carry_d   = ~addSel;
            cnt_d     = '0;
            aMsb_d    = a[WIDTH-1];
            bMsb_d    = b[WIDTH-1];
            addMode_d = addSel;
        end else if (state_q == RUN) begin
            aSh_d   = {1'b0, aSh_q[WIDTH-1:1]};
            bnSh_d  = {1'b0, bnSh_q[WIDTH-1:1]};
            carry_d = carryOut;
            cnt_d   = cnt_q + CW'(1);
            diff_d  = {sumBit, diff_q[WIDTH-1:1]};
            if (lastBit) begin
                borrow_d = addMode_q ? carryOut : ~carryOut;
                if (addMode_q)
                    overflow_d = (aMsb_q == bMsb_q) & (sumBit != aMsb_q);
                else
                    overflow_d = (aMsb_q != bMsb_q) & (sumBit != aMsb_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            aSh_q      <= '0;
            bnSh_q     <= '0;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            aMsb_q     <= 1'b0;
            bMsb_q     <= 1'b0;
            addMode_q  <= 1'b0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            aSh_q      <= aSh_d;
            bnSh_q     <= bnSh_d;
            carry_q    <= carry_d;
            cnt_q      <= cnt_d;
            aMsb_q     <= aMsb_d;
            bMsb_q     <= bMsb_d;
            addMode_q  <= addMode_d;
            diff_q     <= diff_d;
            borrow_q   <= borrow_d;
            overflow_q <= overflow_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: WIDTH=8 directed cases plus an exhaustive WIDTH=4 sweep.
// Add-mode case runs only when SERIAL_SUBTRACTOR_ADD_MODE_EN is defined.
module tb_serial_subtractor;

    typedef struct packed {
        logic [7:0] d;
        logic       br;
        logic       ov;
    } exp8_t;

    typedef struct packed {
        logic [3:0] d;
        logic       br;
        logic       ov;
    } exp4_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       inValid8, inReady8, outValid8, outReady8, borrow8, overflow8, busy8;
    logic [7:0] a8, b8, diff8;
    logic       inValid4, inReady4, outValid4, outReady4, borrow4, overflow4, busy4;
    logic [3:0] a4, b4, diff4;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    logic       opAdd8;
    logic       opAdd4;
`endif

    int checks = 0;
    int passes = 0;
    exp8_t sb8[$];
    exp4_t sb4[$];

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(inValid8), .in_ready(inReady8),
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
        .op_add(opAdd8),
`endif
        .a(a8), .b(b8), .out_valid(outValid8), .out_ready(outReady8),
        .diff(diff8), .borrow(borrow8), .overflow(overflow8), .busy(busy8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(inValid4), .in_ready(inReady4),
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
        .op_add(opAdd4),
`endif
        .a(a4), .b(b4), .out_valid(outValid4), .out_ready(outReady4),
        .diff(diff4), .borrow(borrow4), .overflow(overflow4), .busy(busy4)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    function automatic exp8_t model8(input logic [7:0] x, input logic [7:0] y, input logic addOp);
        exp8_t    e;
        logic [8:0] r;
        if (addOp) begin
            r    = {1'b0, x} + {1'b0, y};
            e.d  = r[7:0];
            e.br = r[8];
            e.ov = (x[7] == y[7]) && (r[7] != x[7]);
        end else begin
            r    = {1'b0, x} - {1'b0, y};
            e.d  = r[7:0];
            e.br = (x < y);
            e.ov = (x[7] != y[7]) && (r[7] != x[7]);
        end
        return e;
    endfunction

    // One full WIDTH=8 transaction; a nonzero holdCycles stalls DONE while offering new operands.
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic addOp, input int holdCycles);
        int    n;
        exp8_t e;
        n = 0;
        while (!inReady8 && n < 50) begin @(posedge clk); #1; n++; end
        if (!inReady8) checkOutput("acceptWait", 0, 1);
        a8 = av;
        b8 = bv;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
        opAdd8 = addOp;
`endif
        inValid8 = 1'b1;
        @(posedge clk); #1;
        inValid8 = 1'b0;
        sb8.push_back(model8(av, bv, addOp));
        checkOutput("busyInRun", {31'd0, busy8}, 1);
        n = 0;
        while (!outValid8 && n < 40) begin @(posedge clk); #1; n++; end
        checkOutput("latency", n, 8);
        if (holdCycles > 0) begin
            a8 = 8'hAA;
            b8 = 8'h55;
            inValid8 = 1'b1;
            repeat (holdCycles) begin
                @(posedge clk); #1;
                checkOutput("holdValid", {31'd0, outValid8}, 1);
                checkOutput("holdReady", {31'd0, inReady8}, 0);
                checkOutput("holdDiff", {24'd0, diff8}, {24'd0, sb8[0].d});
            end
        end
        outReady8 = 1'b1;
        if (sb8.size() == 0) checkOutput("sbEmpty", 0, 1);
        else begin
            e = sb8.pop_front();
            checkOutput("diff", {24'd0, diff8}, {24'd0, e.d});
            checkOutput("borrow", {31'd0, borrow8}, {31'd0, e.br});
            checkOutput("overflow", {31'd0, overflow8}, {31'd0, e.ov});
        end
        @(posedge clk); #1;
        outReady8 = 1'b0;
        inValid8  = 1'b0;
        checkOutput("postValid", {31'd0, outValid8}, 0);
        checkOutput("postReady", {31'd0, inReady8}, 1);
    endtask

    task automatic sweepWidth4();
        int    n;
        int    bad;
        exp4_t e;
        exp4_t m;
        logic [4:0] r;
        bad = 0;
        outReady4 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                n = 0;
                while (!inReady4 && n < 20) begin @(posedge clk); #1; n++; end
                a4 = 4'(i);
                b4 = 4'(j);
                inValid4 = 1'b1;
                @(posedge clk); #1;
                inValid4 = 1'b0;
                r    = {1'b0, a4} - {1'b0, b4};
                m.d  = r[3:0];
                m.br = (i < j);
                m.ov = (a4[3] != b4[3]) && (r[3] != a4[3]);
                sb4.push_back(m);
                n = 0;
                while (!outValid4 && n < 20) begin @(posedge clk); #1; n++; end
                if (!outValid4) checkOutput("w4Timeout", 0, 1);
                else begin
                    e = sb4.pop_front();
                    checkOutput("w4Result", {26'd0, diff4, borrow4, overflow4}, {26'd0, e.d, e.br, e.ov});
                    if ({diff4, borrow4, overflow4} !== {e.d, e.br, e.ov}) bad++;
                end
                @(posedge clk); #1;
            end
        end
        checkOutput("w4SweepBad", bad, 0);
    endtask

    initial begin
        int n;
        logic sawValid;
        rst = 1'b1;
        inValid8 = 1'b0; outReady8 = 1'b0; a8 = '0; b8 = '0;
        inValid4 = 1'b0; outReady4 = 1'b0; a4 = '0; b4 = '0;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
        opAdd8 = 1'b0;
        opAdd4 = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("rstReady", {31'd0, inReady8}, 1);
        checkOutput("rstValid", {31'd0, outValid8}, 0);
        checkOutput("rstDiff", {24'd0, diff8}, 0);
        checkOutput("rstBorrow", {31'd0, borrow8}, 0);
        checkOutput("rstOverflow", {31'd0, overflow8}, 0);
        checkOutput("rstBusy", {31'd0, busy8}, 0);

        applyStimulus(8'h35, 8'h12, 1'b0, 0);
        applyStimulus(8'h05, 8'h07, 1'b0, 0);
        applyStimulus(8'h80, 8'h01, 1'b0, 0);
        applyStimulus(8'h7F, 8'hFF, 1'b0, 0);
        applyStimulus(8'h35, 8'h12, 1'b0, 5);
        applyStimulus(8'hAA, 8'h55, 1'b0, 0);
        applyStimulus(8'h5A, 8'h5A, 1'b0, 0);

        // Abort a=0xF0, b=0x0F partway through RUN; it must leave no result behind.
        a8 = 8'hF0;
        b8 = 8'h0F;
        inValid8 = 1'b1;
        @(posedge clk); #1;
        inValid8 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("abortReady", {31'd0, inReady8}, 1);
        checkOutput("abortValid", {31'd0, outValid8}, 0);
        checkOutput("abortDiff", {24'd0, diff8}, 0);
        checkOutput("abortBorrow", {31'd0, borrow8}, 0);
        checkOutput("abortOverflow", {31'd0, overflow8}, 0);
        checkOutput("abortBusy", {31'd0, busy8}, 0);
        sawValid = 1'b0;
        for (n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (outValid8) sawValid = 1'b1;
        end
        checkOutput("abortNoOutput", {31'd0, sawValid}, 0);
        applyStimulus(8'h10, 8'h10, 1'b0, 0);

`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
        applyStimulus(8'hC8, 8'h40, 1'b1, 0);
        applyStimulus(8'h40, 8'h50, 1'b1, 0);
        applyStimulus(8'h35, 8'h12, 1'b0, 0);
`endif

        sweepWidth4();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor: computes a - b one bit per clock, LSB first.
- Uses one full-adder cell (a_i + ~b_i + carry) and a carry flip-flop. Initial carry is 1, which implements the +1 of two's complement.
- Serves as the sequential, inverse-operation counterpart of the team's combinational full adder.
- Intended as an area-minimal arithmetic unit for low-throughput control paths in the SoC. Valid/ready handshake on both input and output sides.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2 to 32).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a, b present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  a - b modulo 2^WIDTH.
- borrow  output  1  1 when unsigned a < b (inverse of final carry).
- overflow  output  1  signed overflow: sign(a) != sign(b) and sign(diff) != sign(a).
- busy  output  1  high while in RUN.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on the rising edge of clk.
- States: IDLE, RUN, DONE.
- Reset values: state=IDLE, in_ready=1, out_valid=0, diff=0, borrow=0, overflow=0, busy=0. Reset takes priority over all events.
- Reset during RUN or DONE aborts the operation. The partial result is discarded; nothing is output.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch a into a shift register and ~b into a shift register, set carry=1, clear bit counter, go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each cycle: s = a_sh[0] ^ bn_sh[0] ^ carry; carry <= majority(a_sh[0], bn_sh[0], carry).
  - s shifts into diff from the MSB end (diff <= {s, diff[WIDTH-1:1]}). Operand registers shift right by 1.
  - Counter increments. On the cycle processing bit WIDTH-1, go to DONE.
  - borrow <= ~final carry.
  - overflow <= (a[WIDTH-1] != b[WIDTH-1]) & (s_msb != a[WIDTH-1]). Original MSBs are held in dedicated flops captured at accept.
- DONE:
  - out_valid=1.
  - diff, borrow, overflow stable and unchanged while out_valid=1 & out_ready=0.
  - On out_ready: out_valid=0, go to IDLE.
- Latency: accept at edge N; out_valid high from edge N+WIDTH. Exactly WIDTH RUN cycles.
- Throughput: one operation per WIDTH+2 cycles minimum, including the DONE handshake cycle and the IDLE accept cycle.
- No simultaneous accept and output: in_ready=0 in DONE. A back-to-back request waits in IDLE.
- in_valid while in RUN or DONE is ignored. Operands are not sampled.
- diff is visible mid-RUN as a partial value but only meaningful when out_valid=1.
- Operand equality: a=b gives diff=0, borrow=0, overflow=0.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_ADD_MODE_EN.
- Defined:
  - Adds input port op_add (1 bit), sampled with operands at accept.
  - op_add=1 latches b uninverted and sets initial carry=0, so the block computes a + b.
  - In add mode, borrow reports the unsigned carry-out, uninverted.
  - overflow = (a_msb == b_msb) & (sum_msb != a_msb).
- Undefined: port absent; subtract only, behaviour as above.

Test Plan:
- Reset then idle, WIDTH=8 -> in_ready=1, out_valid=0, diff=0x00, borrow=0, overflow=0.
- a=0x35, b=0x12 accepted, out_ready=1 -> out_valid exactly 8 cycles after accept. diff=0x23, borrow=0, overflow=0. in_ready back high the cycle after the DONE handshake.
- a=0x05, b=0x07 -> diff=0xFE, borrow=1, overflow=0. a=0x80, b=0x01 -> diff=0x7F, borrow=0, overflow=1. a=0x7F, b=0xFF -> diff=0x80, borrow=1, overflow=1.
- Hold out_ready=0 for 5 cycles in DONE while driving new in_valid with a=0xAA, b=0x55 -> result held, in_ready=0, new operands not taken. After release, 0xAA-0x55 is accepted and yields diff=0x55.
- Assert rst on RUN cycle 4 of a=0xF0, b=0x0F -> next cycle IDLE, out_valid never asserted, all outputs at reset values. A fresh a=0x10, b=0x10 then yields diff=0x00, borrow=0.
- Exhaustive WIDTH=4 sweep of all 256 a/b pairs against a reference model (a-b mod 16, a<b, signed overflow). With ADD_MODE_EN and op_add=1, a=0xC8, b=0x40 -> diff=0x08, borrow(carry)=1, overflow=0.
